// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, exception codes and field masks.
package cp0_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 8;

   // {rd[4:0], sel[2:0]} register addresses
   localparam logic [ADDR_W-1:0] CP0_INDEX    = 8'h00;
   localparam logic [ADDR_W-1:0] CP0_ENTRYLO0 = 8'h10;
   localparam logic [ADDR_W-1:0] CP0_ENTRYLO1 = 8'h18;
   localparam logic [ADDR_W-1:0] CP0_BADVADDR = 8'h40;
   localparam logic [ADDR_W-1:0] CP0_COUNT    = 8'h48;
   localparam logic [ADDR_W-1:0] CP0_ENTRYHI  = 8'h50;
   localparam logic [ADDR_W-1:0] CP0_COMPARE  = 8'h58;
   localparam logic [ADDR_W-1:0] CP0_STATUS   = 8'h60;
   localparam logic [ADDR_W-1:0] CP0_CAUSE    = 8'h68;
   localparam logic [ADDR_W-1:0] CP0_EPC      = 8'h70;

   // Cause.ExcCode values
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_MOD  = 5'd1;
   localparam logic [4:0] EXC_TLBL = 5'd2;
   localparam logic [4:0] EXC_TLBS = 5'd3;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // Implemented-bit masks
   localparam logic [DATA_W-1:0] ENTRYHI_MASK = 32'hFFFF_E0FF;
   localparam logic [DATA_W-1:0] ENTRYLO_MASK = 32'h03FF_FFFF;
   localparam logic [DATA_W-1:0] STATUS_BEV   = 32'h0040_0000;

   // TLB refill/invalid/modified exceptions reload EntryHi.VPN2
   function automatic logic is_tlb_exc(input logic [4:0] code);
      return (code == EXC_MOD) || (code == EXC_TLBL) || (code == EXC_TLBS);
   endfunction

   // Exceptions that carry a faulting address into BadVAddr
   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code >= EXC_MOD) && (code <= EXC_ADES);
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with prescaler and sticky timer interrupt.
module cp0_timer
   import cp0_pkg::*;
#(
   parameter int unsigned COUNT_DIV = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_count_we,
   input  logic              i_compare_we,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_count,
   output logic [DATA_W-1:0] o_compare,
   output logic              o_ti
);

   localparam int unsigned   PRE_W   = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(COUNT_DIV - 1);

   logic [PRE_W-1:0]  r_pre;
   logic [DATA_W-1:0] r_count;
   logic [DATA_W-1:0] r_compare;
   logic              r_ti;
   logic              r_count_wr;
   logic              w_wrap;
   logic              w_match;

   assign w_wrap  = (r_pre == PRE_MAX);
   // A zero Compare only matches when software just loaded Count to zero
   assign w_match = (r_count == r_compare) && ((r_compare != '0) || r_count_wr);

   // Count/prescaler, Compare and TI state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pre      <= '0;
         r_count    <= '0;
         r_compare  <= '0;
         r_ti       <= 1'b0;
         r_count_wr <= 1'b0;
      end else begin
         if (i_count_we) begin
            r_count <= i_wdata;
            r_pre   <= '0;
         end else if (w_wrap) begin
            r_count <= r_count + 32'd1;
            r_pre   <= '0;
         end else begin
            r_pre   <= r_pre + PRE_W'(1);
         end
         if (i_compare_we) r_compare <= i_wdata;
         if (i_compare_we)  r_ti <= 1'b0;
         else if (w_match)  r_ti <= 1'b1;
         r_count_wr <= i_count_we;
      end
   end

   assign o_count   = r_count;
   assign o_compare = r_compare;
   assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_csr_unit.sv
// CP0 register file written from WB: status, cause, exception, TLB and timer state.
module cp0_csr_unit
   import cp0_pkg::*;
#(
   parameter int unsigned NUM_HW_INT = 6,
   parameter int unsigned COUNT_DIV  = 2,
   parameter int unsigned TLB_IDX_W  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mtc0_we,
   input  logic [ADDR_W-1:0]     cp0_addr,
   input  logic [DATA_W-1:0]     cp0_wdata,
   output logic [DATA_W-1:0]     cp0_rdata,
   input  logic                  wb_ex,
   input  logic [4:0]            wb_excode,
   input  logic                  wb_bd,
   input  logic [DATA_W-1:0]     wb_pc,
   input  logic [DATA_W-1:0]     wb_badvaddr,
   input  logic                  eret_flush,
   input  logic                  tlbp_we,
   input  logic                  tlbp_miss,
   input  logic [TLB_IDX_W-1:0]  tlbp_idx,
   input  logic                  tlbr_we,
   input  logic [DATA_W-1:0]     tlbr_entryhi,
   input  logic [DATA_W-1:0]     tlbr_entrylo0,
   input  logic [DATA_W-1:0]     tlbr_entrylo1,
   input  logic [NUM_HW_INT-1:0] ext_int,
   output logic [DATA_W-1:0]     epc_out,
   output logic [DATA_W-1:0]     entryhi_out,
   output logic [DATA_W-1:0]     entrylo0_out,
   output logic [DATA_W-1:0]     entrylo1_out,
   output logic [TLB_IDX_W-1:0]  index_out,
   output logic                  status_exl,
   output logic                  int_pending
);

   logic [7:0]            r_im;
   logic                  r_ie;
   logic                  r_exl;
   logic                  r_bd;
   logic [4:0]            r_exccode;
   logic [1:0]            r_ip_sw;
   logic [NUM_HW_INT-1:0] r_ip_hw;
   logic [DATA_W-1:0]     r_epc;
   logic [DATA_W-1:0]     r_badvaddr;
   logic [DATA_W-1:0]     r_entryhi;
   logic [DATA_W-1:0]     r_entrylo0;
   logic [DATA_W-1:0]     r_entrylo1;
   logic                  r_index_p;
   logic [TLB_IDX_W-1:0]  r_index;
   logic                  r_int_pending;

   logic                  w_wr_index, w_wr_lo0, w_wr_lo1, w_wr_count, w_wr_hi;
   logic                  w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc;
   logic                  w_ti;
   logic [DATA_W-1:0]     w_count;
   logic [DATA_W-1:0]     w_compare;
   logic [7:0]            w_ip;
   logic [DATA_W-1:0]     w_exc_epc;
   logic                  w_exc_hi;

   assign w_wr_index   = mtc0_we && (cp0_addr == CP0_INDEX);
   assign w_wr_lo0     = mtc0_we && (cp0_addr == CP0_ENTRYLO0);
   assign w_wr_lo1     = mtc0_we && (cp0_addr == CP0_ENTRYLO1);
   assign w_wr_count   = mtc0_we && (cp0_addr == CP0_COUNT);
   assign w_wr_hi      = mtc0_we && (cp0_addr == CP0_ENTRYHI);
   assign w_wr_compare = mtc0_we && (cp0_addr == CP0_COMPARE);
   assign w_wr_status  = mtc0_we && (cp0_addr == CP0_STATUS);
   assign w_wr_cause   = mtc0_we && (cp0_addr == CP0_CAUSE);
   assign w_wr_epc     = mtc0_we && (cp0_addr == CP0_EPC);

   assign w_ip      = (8'(r_ip_hw) << 2) | {w_ti, 5'b0, r_ip_sw};
   assign w_exc_epc = wb_bd ? (wb_pc - 32'd4) : wb_pc;
   assign w_exc_hi  = wb_ex && is_tlb_exc(wb_excode);

   cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
      .clk          (clk),
      .reset        (reset),
      .i_count_we   (w_wr_count),
      .i_compare_we (w_wr_compare),
      .i_wdata      (cp0_wdata),
      .o_count      (w_count),
      .o_compare    (w_compare),
      .o_ti         (w_ti)
   );

   // Reset-initialised register state with exception > TLB > mtc0 priority
   always_ff @(posedge clk) begin
      if (reset) begin
         r_im          <= '0;
         r_ie          <= 1'b0;
         r_exl         <= 1'b0;
         r_bd          <= 1'b0;
         r_exccode     <= '0;
         r_ip_sw       <= '0;
         r_ip_hw       <= '0;
         r_entryhi     <= '0;
         r_entrylo0    <= '0;
         r_entrylo1    <= '0;
         r_index_p     <= 1'b0;
         r_index       <= '0;
         r_int_pending <= 1'b0;
      end else begin
         if (w_wr_status) begin
            r_im <= cp0_wdata[15:8];
            r_ie <= cp0_wdata[0];
         end
         if (wb_ex)            r_exl <= 1'b1;
         else if (eret_flush)  r_exl <= 1'b0;
         else if (w_wr_status) r_exl <= cp0_wdata[1];

         if (wb_ex) begin
            r_exccode <= wb_excode;
            if (!r_exl) r_bd <= wb_bd;
         end
         if (w_wr_cause) r_ip_sw <= cp0_wdata[9:8];
         r_ip_hw <= ext_int;

         if (w_exc_hi)     r_entryhi[31:13] <= wb_badvaddr[31:13];
         else if (tlbr_we) r_entryhi <= tlbr_entryhi & ENTRYHI_MASK;
         else if (w_wr_hi) r_entryhi <= cp0_wdata & ENTRYHI_MASK;

         if (tlbr_we)       r_entrylo0 <= tlbr_entrylo0 & ENTRYLO_MASK;
         else if (w_wr_lo0) r_entrylo0 <= cp0_wdata & ENTRYLO_MASK;
         if (tlbr_we)       r_entrylo1 <= tlbr_entrylo1 & ENTRYLO_MASK;
         else if (w_wr_lo1) r_entrylo1 <= cp0_wdata & ENTRYLO_MASK;

         if (tlbp_we) begin
            r_index_p <= tlbp_miss;
            r_index   <= tlbp_idx;
         end else if (w_wr_index) begin
            r_index   <= cp0_wdata[TLB_IDX_W-1:0];
         end

         r_int_pending <= r_ie & ~r_exl & (|(r_im & w_ip));
      end
   end

   // EPC and BadVAddr carry no reset value
   always_ff @(posedge clk) begin
      if (wb_ex && !r_exl) r_epc <= w_exc_epc;
      else if (w_wr_epc)   r_epc <= cp0_wdata;
      if (wb_ex && is_addr_exc(wb_excode)) r_badvaddr <= wb_badvaddr;
   end

   // mfc0 read mux on pre-write state
   always_comb begin
      cp0_rdata = '0;
      case (cp0_addr)
         CP0_INDEX:    cp0_rdata = {r_index_p, 31'b0} | 32'(r_index);
         CP0_ENTRYLO0: cp0_rdata = r_entrylo0;
         CP0_ENTRYLO1: cp0_rdata = r_entrylo1;
         CP0_BADVADDR: cp0_rdata = r_badvaddr;
         CP0_COUNT:    cp0_rdata = w_count;
         CP0_ENTRYHI:  cp0_rdata = r_entryhi;
         CP0_COMPARE:  cp0_rdata = w_compare;
         CP0_STATUS:   cp0_rdata = STATUS_BEV | {16'b0, r_im, 6'b0, r_exl, r_ie};
         CP0_CAUSE:    cp0_rdata = {r_bd, w_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b0};
         CP0_EPC:      cp0_rdata = r_epc;
         default:      cp0_rdata = '0;
      endcase
   end

   assign epc_out      = r_epc;
   assign entryhi_out  = r_entryhi;
   assign entrylo0_out = r_entrylo0;
   assign entrylo1_out = r_entrylo1;
   assign index_out    = r_index;
   assign status_exl   = r_exl;
   assign int_pending  = r_int_pending;

endmodule

// File: tb/tb_cp0_csr_unit.sv
// Randomised bench for cp0_csr_unit against a behavioural CP0 model.
module tb_cp0_csr_unit;
   import cp0_pkg::*;

   localparam int unsigned NHW = 6;
   localparam int unsigned DIV = 2;
   localparam int unsigned TW  = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           mtc0_we;
   logic [7:0]     cp0_addr;
   logic [31:0]    cp0_wdata;
   logic [31:0]    cp0_rdata;
   logic           wb_ex;
   logic [4:0]     wb_excode;
   logic           wb_bd;
   logic [31:0]    wb_pc;
   logic [31:0]    wb_badvaddr;
   logic           eret_flush;
   logic           tlbp_we;
   logic           tlbp_miss;
   logic [TW-1:0]  tlbp_idx;
   logic           tlbr_we;
   logic [31:0]    tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1;
   logic [NHW-1:0] ext_int;
   logic [31:0]    epc_out, entryhi_out, entrylo0_out, entrylo1_out;
   logic [TW-1:0]  index_out;
   logic           status_exl;
   logic           int_pending;

   cp0_csr_unit #(.NUM_HW_INT(NHW), .COUNT_DIV(DIV), .TLB_IDX_W(TW)) dut (
      .clk(clk), .reset(reset), .mtc0_we(mtc0_we), .cp0_addr(cp0_addr),
      .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .wb_ex(wb_ex),
      .wb_excode(wb_excode), .wb_bd(wb_bd), .wb_pc(wb_pc),
      .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush), .tlbp_we(tlbp_we),
      .tlbp_miss(tlbp_miss), .tlbp_idx(tlbp_idx), .tlbr_we(tlbr_we),
      .tlbr_entryhi(tlbr_entryhi), .tlbr_entrylo0(tlbr_entrylo0),
      .tlbr_entrylo1(tlbr_entrylo1), .ext_int(ext_int), .epc_out(epc_out),
      .entryhi_out(entryhi_out), .entrylo0_out(entrylo0_out),
      .entrylo1_out(entrylo1_out), .index_out(index_out),
      .status_exl(status_exl), .int_pending(int_pending)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]  m_im;
   logic        m_ie, m_exl, m_bd, m_ti, m_cwr, m_intp, m_p;
   logic [4:0]  m_exc;
   logic [1:0]  m_sw;
   logic [5:0]  m_hw;
   logic [31:0] m_epc, m_bva, m_eh, m_lo0, m_lo1, m_compare, m_ld_val;
   logic [TW-1:0] m_idx;
   logic        m_epc_ok = 1'b0;
   logic        m_bva_ok = 1'b0;
   int          m_ld_age;

   // Count = last loaded value plus one per DIV elapsed cycles
   function automatic logic [31:0] m_count();
      return m_ld_val + 32'(m_ld_age / DIV);
   endfunction

   function automatic logic [7:0] m_ip();
      logic [7:0] ip;
      ip = {m_hw, 2'b00} | {6'b0, m_sw};
      if (m_ti) ip[7] = 1'b1;
      return ip;
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] a);
      case (a)
         CP0_INDEX:    return {m_p, 27'b0, m_idx};
         CP0_ENTRYLO0: return m_lo0;
         CP0_ENTRYLO1: return m_lo1;
         CP0_BADVADDR: return m_bva;
         CP0_COUNT:    return m_count();
         CP0_ENTRYHI:  return m_eh;
         CP0_COMPARE:  return m_compare;
         CP0_STATUS:   return 32'h0040_0000 + (32'(m_im) << 8) + (32'(m_exl) << 1) + 32'(m_ie);
         CP0_CAUSE:    return (32'(m_bd) << 31) + (32'(m_ti) << 30) + (32'(m_ip()) << 8) + (32'(m_exc) << 2);
         CP0_EPC:      return m_epc;
         default:      return 32'h0;
      endcase
   endfunction

   task automatic m_reset();
      m_im = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_ti = 0; m_cwr = 0; m_intp = 0;
      m_p = 0; m_exc = 0; m_sw = 0; m_hw = 0; m_eh = 0; m_lo0 = 0; m_lo1 = 0;
      m_compare = 0; m_ld_val = 0; m_ld_age = 0; m_idx = 0;
   endtask

   // Advance the model by one clock edge using the inputs currently applied
   task automatic m_step();
      logic        old_exl, match, w;
      logic [31:0] cnt;
      old_exl = m_exl;
      cnt     = m_count();
      w       = mtc0_we;
      match   = (cnt == m_compare) && (m_compare != 0 || m_cwr);
      m_intp  = m_ie && !m_exl && ((m_im & m_ip()) != 0);
      // timer
      if (w && cp0_addr == CP0_COMPARE) m_ti = 1'b0;
      else if (match)                   m_ti = 1'b1;
      if (w && cp0_addr == CP0_COMPARE) m_compare = cp0_wdata;
      m_cwr = w && cp0_addr == CP0_COUNT;
      if (m_cwr) begin m_ld_val = cp0_wdata; m_ld_age = 0; end
      else m_ld_age++;
      // status
      if (w && cp0_addr == CP0_STATUS) begin
         m_im = cp0_wdata[15:8]; m_ie = cp0_wdata[0]; m_exl = cp0_wdata[1];
      end
      if (eret_flush) m_exl = 1'b0;
      if (wb_ex)      m_exl = 1'b1;
      // cause, epc, badvaddr
      if (w && cp0_addr == CP0_CAUSE) m_sw = cp0_wdata[9:8];
      m_hw = ext_int;
      if (w && cp0_addr == CP0_EPC) begin m_epc = cp0_wdata; m_epc_ok = 1'b1; end
      if (wb_ex) begin
         m_exc = wb_excode;
         if (!old_exl) begin
            m_bd = wb_bd; m_epc = wb_bd ? wb_pc - 4 : wb_pc; m_epc_ok = 1'b1;
         end
         if (wb_excode >= 1 && wb_excode <= 5) begin m_bva = wb_badvaddr; m_bva_ok = 1'b1; end
      end
      // TLB registers
      if (wb_ex && wb_excode >= 1 && wb_excode <= 3) m_eh = {wb_badvaddr[31:13], m_eh[12:0]};
      else if (tlbr_we)                      m_eh = tlbr_entryhi & 32'hFFFF_E0FF;
      else if (w && cp0_addr == CP0_ENTRYHI) m_eh = cp0_wdata & 32'hFFFF_E0FF;
      if (tlbr_we)                            m_lo0 = tlbr_entrylo0 & 32'h03FF_FFFF;
      else if (w && cp0_addr == CP0_ENTRYLO0) m_lo0 = cp0_wdata & 32'h03FF_FFFF;
      if (tlbr_we)                            m_lo1 = tlbr_entrylo1 & 32'h03FF_FFFF;
      else if (w && cp0_addr == CP0_ENTRYLO1) m_lo1 = cp0_wdata & 32'h03FF_FFFF;
      if (tlbp_we) begin m_p = tlbp_miss; m_idx = tlbp_idx; end
      else if (w && cp0_addr == CP0_INDEX) m_idx = cp0_wdata[TW-1:0];
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic clear_inputs();
      mtc0_we = 0; cp0_wdata = 0; wb_ex = 0; wb_excode = 0; wb_bd = 0;
      wb_pc = 0; wb_badvaddr = 0; eret_flush = 0; tlbp_we = 0; tlbp_miss = 0;
      tlbp_idx = 0; tlbr_we = 0; tlbr_entryhi = 0; tlbr_entrylo0 = 0; tlbr_entrylo1 = 0;
   endtask

   task automatic compare_all();
      if (!((cp0_addr == CP0_EPC && !m_epc_ok) || (cp0_addr == CP0_BADVADDR && !m_bva_ok)))
         check_eq($sformatf("rdata@%02h", cp0_addr), cp0_rdata, m_read(cp0_addr));
      if (m_epc_ok) check_eq("epc_out", epc_out, m_epc);
      check_eq("entryhi_out", entryhi_out, m_eh);
      check_eq("entrylo0_out", entrylo0_out, m_lo0);
      check_eq("entrylo1_out", entrylo1_out, m_lo1);
      check_eq("index_out", 32'(index_out), 32'(m_idx));
      check_eq("status_exl", 32'(status_exl), 32'(m_exl));
      check_eq("int_pending", 32'(int_pending), 32'(m_intp));
   endtask

   task automatic tick();
      @(negedge clk);
      if (!reset) compare_all();
      @(posedge clk);
      if (reset) m_reset(); else m_step();
      #1;
   endtask

   task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
      mtc0_we = 1; cp0_addr = a; cp0_wdata = d;
      tick();
      mtc0_we = 0;
   endtask

   task automatic peek(input string tag, input logic [7:0] a, input logic [31:0] exp);
      cp0_addr = a;
      #1;
      check_eq(tag, cp0_rdata, exp);
   endtask

   localparam logic [7:0] REGS [10] = '{CP0_INDEX, CP0_ENTRYLO0, CP0_ENTRYLO1, CP0_BADVADDR,
      CP0_COUNT, CP0_ENTRYHI, CP0_COMPARE, CP0_STATUS, CP0_CAUSE, CP0_EPC};

   initial begin
      reset = 1; ext_int = 0; cp0_addr = 0;
      clear_inputs();
      m_reset();
      repeat (3) tick();
      reset = 0;

      // reset values
      peek("rst_status", CP0_STATUS, 32'h0040_0000);
      peek("rst_cause", CP0_CAUSE, 32'h0);
      peek("rst_count", CP0_COUNT, 32'h0);
      peek("rst_index", CP0_INDEX, 32'h0);
      peek("rst_entryhi", CP0_ENTRYHI, 32'h0);
      check_eq("rst_int_pending", 32'(int_pending), 32'h0);
      for (int i = 0; i < 10; i++) begin cp0_addr = REGS[i]; tick(); end

      // Count wrap with prescaler of two
      mtc0(CP0_COUNT, 32'hFFFF_FFFE);
      cp0_addr = CP0_COUNT;
      repeat (2) tick();
      peek("count_ffff", CP0_COUNT, 32'hFFFF_FFFF);
      repeat (2) tick();
      peek("count_wrap0", CP0_COUNT, 32'h0);

      // Timer interrupt
      mtc0(CP0_COMPARE, 32'd5);
      mtc0(CP0_STATUS, 32'h0000_8001);
      mtc0(CP0_COUNT, 32'd3);
      cp0_addr = CP0_CAUSE;
      repeat (12) tick();
      peek("ti_set", CP0_CAUSE, 32'h4000_8000);
      check_eq("int_pending_ti", 32'(int_pending), 32'h1);
      mtc0(CP0_COMPARE, 32'h100);
      peek("ti_clear", CP0_CAUSE, 32'h0);
      repeat (2) tick();

      // Exception in a delay slot
      wb_ex = 1; wb_excode = EXC_TLBL; wb_bd = 1; wb_pc = 32'hBFC0_0104; wb_badvaddr = 32'h1234_5678;
      tick();
      clear_inputs();
      peek("exc_epc", CP0_EPC, 32'hBFC0_0100);
      peek("exc_bva", CP0_BADVADDR, 32'h1234_5678);
      check_eq("exc_bd", 32'(cp0_rdata != 0), 32'h1);
      peek("exc_cause_bd", CP0_CAUSE, 32'h8000_0008);
      check_eq("exc_vpn2", 32'(entryhi_out[31:13]), 32'h091A2);
      check_eq("exc_exl", 32'(status_exl), 32'h1);
      wb_ex = 1; wb_excode = EXC_ADEL; wb_bd = 0; wb_pc = 32'h8000_0000; wb_badvaddr = 32'h4;
      tick();
      clear_inputs();
      peek("exc2_epc_kept", CP0_EPC, 32'hBFC0_0100);
      peek("exc2_cause", CP0_CAUSE, 32'h8000_0010);
      eret_flush = 1; tick(); eret_flush = 0;
      check_eq("eret_exl", 32'(status_exl), 32'h0);

      // tlbp / tlbr
      tlbp_we = 1; tlbp_miss = 1; tlbp_idx = 0; tick();
      peek("tlbp_miss", CP0_INDEX, 32'h8000_0000);
      tlbp_miss = 0; tlbp_idx = 7; tick(); tlbp_we = 0;
      peek("tlbp_hit", CP0_INDEX, 32'h7);
      tlbr_we = 1; tlbr_entryhi = '1; tlbr_entrylo0 = '1; tlbr_entrylo1 = '1; tick();
      clear_inputs();
      peek("tlbr_hi", CP0_ENTRYHI, 32'hFFFF_E0FF);
      peek("tlbr_lo0", CP0_ENTRYLO0, 32'h03FF_FFFF);
      peek("tlbr_lo1", CP0_ENTRYLO1, 32'h03FF_FFFF);

      // Same-cycle conflicts
      wb_ex = 1; wb_excode = EXC_SYS; mtc0_we = 1; cp0_addr = CP0_STATUS; cp0_wdata = 0;
      tick();
      clear_inputs();
      check_eq("conflict_exl", 32'(status_exl), 32'h1);
      eret_flush = 1; tick(); eret_flush = 0;
      for (int i = 0; i < 4 && (m_ld_age % DIV) != DIV - 1; i++) tick();
      mtc0(CP0_COUNT, 32'h10);
      peek("count_load_wins", CP0_COUNT, 32'h10);

      // Randomised traffic
      for (int c = 0; c < 3000; c++) begin
         clear_inputs();
         cp0_addr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : REGS[$urandom_range(0, 9)];
         if ($urandom_range(0, 9) < 3) begin
            mtc0_we = 1;
            cp0_wdata = $urandom;
            if (cp0_addr == CP0_COMPARE && $urandom_range(0, 1) == 1)
               cp0_wdata = m_count() + 32'($urandom_range(0, 6));
            if (cp0_addr == CP0_STATUS && $urandom_range(0, 1) == 1)
               cp0_wdata = cp0_wdata & 32'hFFFF_FFFD;
         end
         if ($urandom_range(0, 19) == 0) begin
            wb_ex = 1;
            wb_excode = $urandom_range(0, 1) ? 5'($urandom_range(0, 5)) : 5'($urandom);
            wb_bd = 1'($urandom); wb_pc = $urandom; wb_badvaddr = $urandom;
         end
         if ($urandom_range(0, 9) == 0) eret_flush = 1;
         if ($urandom_range(0, 14) == 0) begin
            tlbp_we = 1; tlbp_miss = 1'($urandom); tlbp_idx = TW'($urandom);
         end
         if ($urandom_range(0, 14) == 0) begin
            tlbr_we = 1; tlbr_entryhi = $urandom; tlbr_entrylo0 = $urandom; tlbr_entrylo1 = $urandom;
         end
         if ($urandom_range(0, 9) == 0) ext_int = NHW'($urandom);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
